// File: rtl/mdu_unit_if.sv
// mdu_unit_if: E-stage multiply/divide bus between the pipeline and the MDU.
//   E_MDUOp  op of the instruction in E (0 none, 1 mult, 2 multu, 3 div,
//            4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none)
//   E_A/E_B  forwarded rs/rt operands
//   Start    MD arithmetic op accepted this cycle
//   Busy     unit occupied
//   HI/LO    architectural HI/LO registers
//   MDU_Out  mfhi/mflo read data, 0 otherwise
// master = pipeline/hazard side, slave = mdu_unit.
interface mdu_unit_if;
   logic [3:0]  E_MDUOp;
   logic [31:0] E_A;
   logic [31:0] E_B;
   logic        Start;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDU_Out;

   modport master (
      output E_MDUOp, E_A, E_B,
      input  Start, Busy, HI, LO, MDU_Out
   );

   modport slave (
      input  E_MDUOp, E_A, E_B,
      output Start, Busy, HI, LO, MDU_Out
   );
endinterface

// File: rtl/mdu_unit.sv
// mdu_unit: fixed-latency multiply/divide unit owning HI/LO.
//   clk    pipeline clock, rising edge
//   reset  asynchronous, active-low
//   bus    mdu_unit_if.slave (op/operands in; Start, Busy, HI, LO, MDU_Out out)
// The 64-bit result is computed at the start edge into shadow registers and
// committed to HI/LO on the last Busy cycle, so HI/LO always show the old
// value while the unit is occupied.
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic          clk,
   input logic          reset,
   mdu_unit_if.slave    bus
);
   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_reg;
   logic               busy_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [31:0]        hi_reg;
   logic [31:0]        lo_reg;
   logic [31:0]        shadow_hi_reg;
   logic [31:0]        shadow_lo_reg;
   logic               div_zero_reg;

   logic               start;
   logic [63:0]        result_next;
   logic               div_zero_next;
   logic [CNT_W-1:0]   cnt_load;
   logic [31:0]        a_mag;
   logic [31:0]        b_mag;
   logic [31:0]        dividend;
   logic [31:0]        divisor;
   logic [31:0]        quot;
   logic [31:0]        rem;

   assign start = !busy_reg && (bus.E_MDUOp inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});

   // Signed divide works on magnitudes and fixes signs afterwards; this makes
   // 0x80000000 / -1 fall out naturally (magnitude 0x80000000 negates to itself).
   always_comb begin
      result_next   = '0;
      div_zero_next = 1'b0;
      cnt_load      = CNT_W'(MULT_CYCLES);
      a_mag         = bus.E_A[31] ? (~bus.E_A + 32'd1) : bus.E_A;
      b_mag         = bus.E_B[31] ? (~bus.E_B + 32'd1) : bus.E_B;
      dividend      = bus.E_A;
      divisor       = 32'd1;
      quot          = '0;
      rem           = '0;
      case (bus.E_MDUOp)
         OP_MULT:  result_next = $signed({{32{bus.E_A[31]}}, bus.E_A}) *
                                 $signed({{32{bus.E_B[31]}}, bus.E_B});
         OP_MULTU: result_next = {32'd0, bus.E_A} * {32'd0, bus.E_B};
         OP_DIV, OP_DIVU: begin
            cnt_load      = CNT_W'(DIV_CYCLES);
            div_zero_next = (bus.E_B == 32'd0);
            if (bus.E_MDUOp == OP_DIV) begin
               dividend = a_mag;
               divisor  = b_mag;
            end else begin
               dividend = bus.E_A;
               divisor  = bus.E_B;
            end
            // Keep the divider away from a zero divisor; the result is discarded anyway.
            if (divisor == 32'd0)
               divisor = 32'd1;
            quot = dividend / divisor;
            rem  = dividend % divisor;
            if (bus.E_MDUOp == OP_DIV) begin
               if (bus.E_A[31] ^ bus.E_B[31])
                  quot = ~quot + 32'd1;
               if (bus.E_A[31])
                  rem = ~rem + 32'd1;
            end
            result_next = {rem, quot};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         busy_reg      <= 1'b0;
         cnt_reg       <= '0;
         hi_reg        <= '0;
         lo_reg        <= '0;
         shadow_hi_reg <= '0;
         shadow_lo_reg <= '0;
         div_zero_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  shadow_hi_reg <= result_next[63:32];
                  shadow_lo_reg <= result_next[31:0];
                  div_zero_reg  <= div_zero_next;
                  cnt_reg       <= cnt_load;
                  busy_reg      <= 1'b1;
                  state_reg     <= RUN;
               end else if (bus.E_MDUOp == OP_MTHI) begin
                  hi_reg <= bus.E_A;
               end else if (bus.E_MDUOp == OP_MTLO) begin
                  lo_reg <= bus.E_A;
               end
            end
            RUN: begin
               // Any MD op presented here is ignored by construction.
               if (cnt_reg == CNT_W'(1)) begin
                  if (!div_zero_reg) begin
                     hi_reg <= shadow_hi_reg;
                     lo_reg <= shadow_lo_reg;
                  end
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Start   = start;
   assign bus.Busy    = busy_reg;
   assign bus.HI      = hi_reg;
   assign bus.LO      = lo_reg;
   assign bus.MDU_Out = (bus.E_MDUOp == OP_MFHI) ? hi_reg :
                        (bus.E_MDUOp == OP_MFLO) ? lo_reg : 32'd0;
endmodule
